// File: rtl/dp2mem.sv
// Debug-port to memory bridge: shifts a {header, address, data} frame in over 1/8/16/32 pin lanes,
// issues one memory request, and shifts back start/ACK/parity-or-data/stop on the same pins.
module dp2mem #(
  parameter int N_DW  = 32,
  parameter int N_DM  = 4,
  parameter int N_DIO = 32
) (
  input  logic                    dp_clk_i,
  input  logic                    dp_rstn_i,
  input  logic [1:0]              dp_mod_i,
  input  logic [N_DIO-1:0]        dp_dat_i,
  output logic [N_DIO-1:0]        dp_dat_o,
  output logic [N_DIO-1:0]        dp_dat_oen,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [2*N_DW+N_DM:0]    mem_req,        // {req_type, req_addr, req_data, req_mask}
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  logic [N_DW-1:0]         mem_resp,       // resp_data
  output logic                    dp_busy_o
);

  typedef enum logic [3:0] {
    IDLE, RX_HDR, RX_ADDR, RX_DATA, MEM_REQ, MEM_RESP,
    TURN, TX_START, TX_ACK, TX_PARITY, TX_DATA, TX_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [31:0]      sr_q, sr_d, hdr_q, hdr_d, addr_q, addr_d, data_q, data_d, tx_q, tx_d;
  logic [N_DIO-1:0] pin_o_q, pin_o_d, pin_oen_q, pin_oen_d;
  logic [31:0]      din, shifted, lane;
  logic [4:0]       last_cnt, wmask;
  logic             hdr_bad, last_beat, shift_st, drive;

  if (N_DIO >= 32) begin : g_din_wide
    assign din = dp_dat_i[31:0];
  end else begin : g_din_narrow
    assign din = {{(32-N_DIO){1'b1}}, dp_dat_i};
  end

  always_comb begin
    last_cnt = 5'd0;
    wmask    = 5'd31;
    shifted  = din;
    unique case (mode_q)
      2'b00: begin last_cnt = 5'd31; wmask = 5'd0;  shifted = {din[0],    sr_q[31:1]};  end
      2'b01: begin last_cnt = 5'd3;  wmask = 5'd7;  shifted = {din[7:0],  sr_q[31:8]};  end
      2'b10: begin last_cnt = 5'd1;  wmask = 5'd15; shifted = {din[15:0], sr_q[31:16]}; end
      default: ;
    endcase
  end

  assign hdr_bad   = |hdr_q[31:5];
  assign last_beat = (cnt_q == last_cnt);
  assign shift_st  = (state_q == RX_HDR) || (state_q == RX_ADDR) ||
                     (state_q == RX_DATA) || (state_q == TX_DATA);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sr_d    = sr_q;
    hdr_d   = hdr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: if (!din[0]) begin
        state_d = RX_HDR;
        mode_d  = dp_mod_i;
      end
      RX_HDR: begin
        sr_d = shifted;
        if (last_beat) begin
          hdr_d   = shifted;
          state_d = RX_ADDR;
        end
      end
      RX_ADDR: begin
        sr_d = shifted;
        if (last_beat) begin
          addr_d = shifted;
          if (hdr_q[0])     state_d = RX_DATA;
          else if (hdr_bad) state_d = TURN;
          else              state_d = MEM_REQ;
        end
      end
      RX_DATA: begin
        sr_d = shifted;
        if (last_beat) begin
          data_d  = shifted;
          state_d = hdr_bad ? TURN : MEM_REQ;
        end
      end
      MEM_REQ:  if (mem_req_ready) state_d = MEM_RESP;
      MEM_RESP: if (mem_resp_valid) begin
        tx_d    = 32'(mem_resp);
        state_d = TURN;
      end
      TURN:     state_d = TX_START;
      TX_START: state_d = TX_ACK;
      TX_ACK: begin
        if (hdr_bad)       state_d = TX_STOP;
        else if (hdr_q[0]) state_d = TX_PARITY;
        else               state_d = TX_DATA;
      end
      TX_PARITY: state_d = TX_STOP;
      TX_DATA: begin
        tx_d = tx_q >> (32'(wmask) + 32'd1);
        if (last_beat) state_d = TX_STOP;
      end
      TX_STOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = ((state_d != state_q) || !shift_st) ? '0 : cnt_q + 5'd1;
  end

  always_ff @(posedge dp_clk_i or negedge dp_rstn_i) begin
    if (!dp_rstn_i) begin
      state_q <= IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      hdr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      hdr_q   <= hdr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  // Low W bits of lane carry the beat; every pin i mirrors lane bit (i mod W).
  always_comb begin
    lane  = '0;
    drive = 1'b1;
    unique case (state_q)
      TX_START:  lane = '0;
      TX_ACK:    lane[0] = !hdr_bad;
      TX_PARITY: lane[0] = ^data_q;
      TX_DATA:   lane = tx_q;
      TX_STOP:   lane = '1;
      default:   drive = 1'b0;
    endcase
    pin_oen_d = drive ? '0 : '1;
    pin_o_d   = '0;
    if (drive) begin
      for (int unsigned i = 0; i < N_DIO; i++) pin_o_d[i] = lane[5'(i) & wmask];
    end
  end

  always_ff @(negedge dp_clk_i or negedge dp_rstn_i) begin
    if (!dp_rstn_i) begin
      pin_o_q   <= '0;
      pin_oen_q <= '1;
    end else begin
      pin_o_q   <= pin_o_d;
      pin_oen_q <= pin_oen_d;
    end
  end

  assign dp_dat_o       = pin_o_q;
  assign dp_dat_oen     = pin_oen_q;
  assign mem_req_valid  = (state_q == MEM_REQ);
  assign mem_resp_ready = (state_q == MEM_RESP);
  assign mem_req        = {hdr_q[0], N_DW'(addr_q), N_DW'(data_q), N_DM'(hdr_q[4:1])};
  assign dp_busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dp2mem.sv
// Directed bench for dp2mem: table of whole frames plus reset-abort sequence.
module tb_dp2mem;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [1:0]  dp_mod_i = 2'b11;
  logic [31:0] dp_dat_i = '1;
  logic [31:0] dp_dat_o, dp_dat_oen;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [68:0] mem_req;
  logic        mem_resp_valid = 1'b0, mem_resp_ready;
  logic [31:0] mem_resp = '0;
  logic        dp_busy_o;

  int total = 0;
  int bad   = 0;

  dp2mem #(.N_DW(32), .N_DM(4), .N_DIO(32)) dut (
    .dp_clk_i      (clk),
    .dp_rstn_i     (rstn),
    .dp_mod_i      (dp_mod_i),
    .dp_dat_i      (dp_dat_i),
    .dp_dat_o      (dp_dat_o),
    .dp_dat_oen    (dp_dat_oen),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req       (mem_req),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready),
    .mem_resp      (mem_resp),
    .dp_busy_o     (dp_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic        glitch;     // change dp_mod_i to glitch_mod right after the start beat
    logic [1:0]  glitch_mod;
    logic [31:0] hdr, addr, data, resp;
    int unsigned delay;      // cycles mem_req_ready is held low
    logic        exp_mem;
    logic [3:0]  exp_mask;
    logic        exp_ack;
    logic        exp_par;
  } row_t;

  row_t rows[7];

  function automatic row_t mk(input logic [1:0] mode, input logic glitch, input logic [1:0] gmod,
                              input logic [31:0] hdr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] resp, input int unsigned delay, input logic exp_mem,
                              input logic [3:0] exp_mask, input logic exp_ack, input logic exp_par);
    row_t r;
    r.mode = mode; r.glitch = glitch; r.glitch_mod = gmod;
    r.hdr = hdr; r.addr = addr; r.data = data; r.resp = resp; r.delay = delay;
    r.exp_mem = exp_mem; r.exp_mask = exp_mask; r.exp_ack = exp_ack; r.exp_par = exp_par;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  function automatic int unsigned width(input logic [1:0] m);
    case (m)
      2'd0: return 1;
      2'd1: return 8;
      2'd2: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] rep(input logic [31:0] v, input logic [1:0] m);
    case (m)
      2'd0: return {32{v[0]}};
      2'd1: return {4{v[7:0]}};
      2'd2: return {2{v[15:0]}};
      default: return v;
    endcase
  endfunction

  task automatic send_word(input logic [31:0] w, input logic [1:0] m);
    int unsigned wd = width(m);
    logic [31:0] msk = (wd == 32) ? 32'hFFFF_FFFF : ((32'd1 << wd) - 32'd1);
    for (int unsigned k = 0; k < 32 / wd; k++) begin
      dp_dat_i = ((w >> (k * wd)) & msk) | ~msk;
      tick;
    end
  endtask

  task automatic send_start(input logic [1:0] m);
    dp_dat_i = '1;
    dp_mod_i = m;
    tick;
    chk("idle_busy", 128'(dp_busy_o), 128'(1'b0));
    dp_dat_i = '0;
    tick;
    chk("start_busy", 128'(dp_busy_o), 128'(1'b1));
  endtask

  task automatic mem_handshake(input row_t r);
    logic [68:0] exp_req, act_req;
    exp_req = {r.hdr[0], r.addr, (r.hdr[0] ? r.data : 32'd0), r.exp_mask};
    for (int unsigned d = 0; d <= r.delay; d++) begin
      mem_req_ready = (d == r.delay);
      act_req = mem_req;
      if (!r.hdr[0]) act_req[35:4] = '0;
      chk("req_valid", 128'(mem_req_valid), 128'(1'b1));
      chk("req_fields", 128'(act_req), 128'(exp_req));
      tick;
    end
    mem_req_ready = 1'b0;
    chk("req_valid_drop", 128'(mem_req_valid), 128'(1'b0));
    chk("resp_ready", 128'(mem_resp_ready), 128'(1'b1));
    mem_resp_valid = 1'b1;
    mem_resp = r.resp;
    tick;
    mem_resp_valid = 1'b0;
    mem_resp = ~r.resp;
    chk("resp_ready_drop", 128'(mem_resp_ready), 128'(1'b0));
  endtask

  task automatic run_frame(input row_t r);
    logic [1:0] m = r.mode;
    send_start(m);
    if (r.glitch) dp_mod_i = r.glitch_mod;
    send_word(r.hdr, m);
    send_word(r.addr, m);
    if (r.hdr[0]) send_word(r.data, m);
    dp_dat_i = '0;
    if (r.exp_mem) mem_handshake(r);
    else chk("no_req_valid", 128'(mem_req_valid), 128'(1'b0));
    chk("turn_oen", 128'(dp_dat_oen), 128'(32'hFFFF_FFFF));
    chk("turn_busy", 128'(dp_busy_o), 128'(1'b1));
    tick;
    chk("start_oen", 128'(dp_dat_oen), 128'(32'd0));
    chk("start_dat", 128'(dp_dat_o), 128'(32'd0));
    tick;
    chk("ack_dat", 128'(dp_dat_o), 128'(rep({31'd0, r.exp_ack}, m)));
    tick;
    if (r.exp_ack && r.hdr[0]) begin
      chk("parity_dat", 128'(dp_dat_o), 128'(rep({31'd0, r.exp_par}, m)));
      tick;
    end else if (r.exp_ack) begin
      for (int unsigned k = 0; k < 32 / width(m); k++) begin
        chk("tx_data", 128'(dp_dat_o), 128'(rep(r.resp >> (k * width(m)), m)));
        tick;
      end
    end
    chk("stop_dat", 128'(dp_dat_o), 128'(32'hFFFF_FFFF));
    chk("stop_oen", 128'(dp_dat_oen), 128'(32'd0));
    tick;
    chk("end_oen", 128'(dp_dat_oen), 128'(32'hFFFF_FFFF));
    chk("end_busy", 128'(dp_busy_o), 128'(1'b0));
    dp_dat_i = '1;
    dp_mod_i = m;
  endtask

  initial begin
    //           mode  gl  gmod   hdr           addr          data          resp          dly mem mask  ack par
    rows[0] = mk(2'd3, 0, 2'd0, 32'h0000_001F, 32'h1000_0040, 32'h0000_0003, 32'h0,        0, 1, 4'hF, 1, 0);
    rows[1] = mk(2'd0, 0, 2'd0, 32'h0000_0000, 32'h8000_0000, 32'h0,         32'hDEAD_BEEF, 0, 1, 4'h0, 1, 0);
    rows[2] = mk(2'd1, 0, 2'd0, 32'h0000_0003, 32'h0000_0010, 32'h0000_0001, 32'h0,        5, 1, 4'h1, 1, 1);
    rows[3] = mk(2'd3, 0, 2'd0, 32'h0000_0020, 32'h0000_0100, 32'h0,         32'h0,        0, 0, 4'h0, 0, 0);
    rows[4] = mk(2'd2, 0, 2'd0, 32'h0000_000A, 32'hCAFE_0004, 32'h0,         32'h1234_5678, 2, 1, 4'h5, 1, 0);
    rows[5] = mk(2'd1, 1, 2'd3, 32'h0000_001B, 32'h2000_0000, 32'h8000_0001, 32'h0,        1, 1, 4'hD, 1, 0);
    rows[6] = mk(2'd2, 0, 2'd0, 32'h0000_0021, 32'h0000_0008, 32'h0000_0007, 32'h0,        0, 0, 4'h0, 0, 0);

    #2 rstn = 1'b0;
    #1;
    chk("rst_dat", 128'(dp_dat_o), 128'(32'd0));
    chk("rst_oen", 128'(dp_dat_oen), 128'(32'hFFFF_FFFF));
    chk("rst_valid", 128'(mem_req_valid), 128'(1'b0));
    chk("rst_resp_ready", 128'(mem_resp_ready), 128'(1'b0));
    chk("rst_busy", 128'(dp_busy_o), 128'(1'b0));
    tick;
    tick;
    rstn = 1'b1;
    tick;
    chk("idle_bus_busy", 128'(dp_busy_o), 128'(1'b0));

    for (int i = 0; i < 7; i++) run_frame(rows[i]);

    // Bit-mode read aborted by reset three beats into TX_DATA.
    begin
      row_t r = mk(2'd0, 0, 2'd0, 32'h0, 32'h0000_0004, 32'h0, 32'hA5A5_0F0F, 0, 1, 4'h0, 1, 0);
      send_start(2'd0);
      send_word(r.hdr, 2'd0);
      send_word(r.addr, 2'd0);
      dp_dat_i = '0;
      mem_handshake(r);
      tick;
      tick;
      tick;
      for (int unsigned k = 0; k < 3; k++) begin
        chk("abort_tx_data", 128'(dp_dat_o), 128'(rep(r.resp >> k, 2'd0)));
        tick;
      end
      rstn = 1'b0;
      #1;
      chk("abort_oen", 128'(dp_dat_oen), 128'(32'hFFFF_FFFF));
      chk("abort_dat", 128'(dp_dat_o), 128'(32'd0));
      chk("abort_busy", 128'(dp_busy_o), 128'(1'b0));
      tick;
      rstn = 1'b1;
      dp_dat_i = '1;
      tick;
      tick;
      chk("abort_stay_idle", 128'(dp_busy_o), 128'(1'b0));
      chk("abort_stay_oen", 128'(dp_dat_oen), 128'(32'hFFFF_FFFF));
      run_frame(mk(2'd3, 0, 2'd0, 32'h0000_0010, 32'h0000_0ABC, 32'h0, 32'h0BAD_F00D, 0, 1, 4'h8, 1, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
